// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the hazard controller: register address width,
// memory-wait FSM encodings and the shadow scoreboard entry layout.
package hazard_controller_pkg;

    localparam int REGFILE_ADDRESS_LEN = 4;

    // Wait counter is 8 bits wide and saturates instead of wrapping.
    localparam int          WAIT_CNT_W   = 8;
    localparam logic [7:0]  WAIT_CNT_MAX = 8'hFF;

    // Memory wait FSM encodings.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // One in-flight instruction that will write the register file.
    typedef struct packed {
        logic                           valid;
        logic [REGFILE_ADDRESS_LEN-1:0] dest;
        logic                           mem_read;
    } sb_entry_t;

    // True when a live entry will write the register a source reads.
    function automatic logic entry_hit(input sb_entry_t e,
                                       input logic [REGFILE_ADDRESS_LEN-1:0] src);
        return e.valid && (e.dest == src);
    endfunction

endpackage

// File: rtl/hazard_controller_mem_wait_fsm.sv
// SRAM wait tracker: freezes the pipeline while a MEM access is stalled,
// counts the wait cycles and latches a sticky timeout error.
import hazard_controller_pkg::*;

module mem_wait_fsm #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    input  logic sram_ready,
    output logic freeze,
    output logic mem_timeout
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(WAIT_MAX);

    mem_state_e             state, next_state;
    logic [WAIT_CNT_W-1:0]  wait_cnt;

    // State register; reset abandons any outstanding wait.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next state and freeze; freeze drops in the cycle the SRAM completes.
    always_comb begin
        next_state = state;
        freeze     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req && !sram_ready) begin
                    next_state = WAIT;
                    freeze     = 1'b1;
                end
            end
            WAIT: begin
                if (sram_ready) next_state = IDLE;
                else            freeze     = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // Wait-cycle counter: starts at 1 on entering WAIT, saturates at max.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (mem_req && !sram_ready) wait_cnt <= WAIT_CNT_W'(1);
                WAIT: if (!sram_ready && wait_cnt != WAIT_CNT_MAX)
                          wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                default: wait_cnt <= '0;
            endcase
        end
    end

    // Sticky timeout: once the limit is hit with no completion, only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst)
            mem_timeout <= 1'b0;
        else if (state == WAIT && wait_cnt == WAIT_LIMIT && !sram_ready)
            mem_timeout <= 1'b1;
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: shadow scoreboard of the EXE/MEM writers,
// RAW stall detection, branch flush and SRAM-wait freeze.
import hazard_controller_pkg::*;

module hazard_controller #(
    parameter int FORWARD_EN = 0,
    parameter int WAIT_MAX   = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REGFILE_ADDRESS_LEN-1:0] id_src1,
    input  logic [REGFILE_ADDRESS_LEN-1:0] id_src2,
    input  logic                           id_two_src,
    input  logic                           id_wb_en,
    input  logic                           id_mem_read,
    input  logic [REGFILE_ADDRESS_LEN-1:0] id_dest,
    input  logic                           exe_branch_taken,
    input  logic                           mem_req,
    input  logic                           sram_ready,
    output logic                           hazard,
    output logic                           flush,
    output logic                           freeze,
    output logic                           mem_timeout
);

    sb_entry_t sb_e, sb_m, id_entry;
    logic      match_src1, match_src2, hazard_raw;

    // The MEM entry's load flag never matters for stalling decisions; kept
    // in the entry so both stages share one layout.
    logic unused_m_mem_read;
    assign unused_m_mem_read = sb_m.mem_read;

    mem_wait_fsm #(
        .WAIT_MAX (WAIT_MAX)
    ) u_mem_wait (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .sram_ready  (sram_ready),
        .freeze      (freeze),
        .mem_timeout (mem_timeout)
    );

    // Raw RAW-conflict detection against the scoreboard.
    always_comb begin
        match_src1 = entry_hit(sb_e, id_src1) || entry_hit(sb_m, id_src1);
        match_src2 = entry_hit(sb_e, id_src2) || entry_hit(sb_m, id_src2);
        if (FORWARD_EN != 0)
            // With forwarding only a load still in EXE cannot be bypassed.
            hazard_raw = sb_e.valid && sb_e.mem_read &&
                         ((sb_e.dest == id_src1) ||
                          (id_two_src && (sb_e.dest == id_src2)));
        else
            hazard_raw = match_src1 || (id_two_src && match_src2);
    end

    // A frozen pipeline defers the flush; a flush kills the stall.
    always_comb begin
        flush  = exe_branch_taken && !freeze;
        hazard = hazard_raw && !flush;
    end

    // Entry the ID instruction would deposit in EXE; bubbles are invalid.
    always_comb begin
        id_entry = '0;
        if (!hazard && !flush && id_wb_en) begin
            id_entry.valid    = 1'b1;
            id_entry.dest     = id_dest;
            id_entry.mem_read = id_mem_read;
        end
    end

    // Scoreboard advances with the pipeline and holds while frozen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sb_e <= '0;
            sb_m <= '0;
        end else if (!freeze) begin
            sb_m <= sb_e;
            sb_e <= id_entry;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller. Two instances share stimulus:
// u0 without forwarding (WAIT_MAX=15), u1 with forwarding (WAIT_MAX=3).
// Stimulus queues expected outputs; a negedge monitor pops and compares.
module tb_hazard_controller;

    localparam int HZ = 0, FL = 1, FZ = 2, TO = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       id_two_src, id_wb_en, id_mem_read;
    logic       exe_branch_taken, mem_req, sram_ready;
    logic       hazard0, flush0, freeze0, tmo0;
    logic       hazard1, flush1, freeze1, tmo1;

    always #5 clk = ~clk;

    hazard_controller #(.FORWARD_EN(0), .WAIT_MAX(15)) u0 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .id_dest(id_dest), .exe_branch_taken(exe_branch_taken), .mem_req(mem_req),
        .sram_ready(sram_ready), .hazard(hazard0), .flush(flush0),
        .freeze(freeze0), .mem_timeout(tmo0)
    );

    hazard_controller #(.FORWARD_EN(1), .WAIT_MAX(3)) u1 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .id_dest(id_dest), .exe_branch_taken(exe_branch_taken), .mem_req(mem_req),
        .sram_ready(sram_ready), .hazard(hazard1), .flush(flush1),
        .freeze(freeze1), .mem_timeout(tmo1)
    );

    typedef struct {
        int    u;
        int    sel;
        logic  val;
        string name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic pick(input int u, input int sel);
        logic r;
        r = 1'bx;
        case (sel)
            HZ: r = (u == 0) ? hazard0 : hazard1;
            FL: r = (u == 0) ? flush0  : flush1;
            FZ: r = (u == 0) ? freeze0 : freeze1;
            TO: r = (u == 0) ? tmo0    : tmo1;
            default: r = 1'bx;
        endcase
        return r;
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            HZ: return "hazard";
            FL: return "flush";
            FZ: return "freeze";
            default: return "mem_timeout";
        endcase
    endfunction

    // Monitor: every expectation queued for this cycle is compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic got;
        while (q.size() > 0) begin
            e   = q.pop_front();
            got = pick(e.u, e.sel);
            total++;
            if (got !== e.val) begin
                bad++;
                $display("FAIL %s u%0d %s: got %b expected %b",
                         e.name, e.u, sel_name(e.sel), got, e.val);
            end
        end
    end

    task automatic chk(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic ex(input string name, input int sel, input logic v0, input logic v1);
        exp_t e;
        e.sel = sel; e.name = name;
        e.u = 0; e.val = v0; q.push_back(e);
        e.u = 1; e.val = v1; q.push_back(e);
    endtask

    task automatic id_set(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                          input logic wb, input logic mr, input logic [3:0] d);
        id_src1 = s1; id_src2 = s2; id_two_src = two;
        id_wb_en = wb; id_mem_read = mr; id_dest = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        id_set(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick;
        tick;
    endtask

    initial begin
        rst = 1'b0;
        exe_branch_taken = 1'b0; mem_req = 1'b0; sram_ready = 1'b0;
        id_set(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick;
        tick;
        chk("rst_direct u0 hazard", hazard0, 1'b0);
        chk("rst_direct u0 freeze", freeze0, 1'b0);
        chk("rst_direct u0 timeout", tmo0, 1'b0);
        chk("rst_direct u1 timeout", tmo1, 1'b0);
        ex("rst", HZ, 0, 0); ex("rst", FL, 0, 0); ex("rst", FZ, 0, 0); ex("rst", TO, 0, 0);
        tick;
        rst = 1'b1;

        // RAW on R3 without forwarding: two stall cycles, then clear.
        id_set(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd3); ex("a0", HZ, 0, 0); tick;
        id_set(4'd3, 4'd0, 1'b0, 1'b1, 1'b0, 4'd4); ex("a1", HZ, 1, 0); tick;
        ex("a2", HZ, 1, 0); tick;
        ex("a3", HZ, 0, 0); tick;
        id_set(4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0); ex("a4_probe", HZ, 1, 0); tick;
        drain;

        // Load-use through src2 with forwarding: exactly one stall cycle.
        id_set(4'd1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd5); ex("b0", HZ, 0, 0); tick;
        id_set(4'd2, 4'd5, 1'b1, 1'b1, 1'b0, 4'd6); ex("b1_ldr", HZ, 1, 1); tick;
        ex("b2_ldr", HZ, 1, 0); tick;
        drain;
        // Non-load producer of R5: forwarding covers it.
        id_set(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd5); ex("b3", HZ, 0, 0); tick;
        id_set(4'd2, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0); ex("b4_add", HZ, 1, 0); tick;
        // src2 ignored when two_src=0.
        id_set(4'd0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0); ex("b5_one_src", HZ, 0, 0); tick;
        drain;

        // Branch taken while ID would stall: flush wins, EXE gets a bubble.
        id_set(4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd7); ex("c0", HZ, 0, 0); tick;
        id_set(4'd7, 4'd0, 1'b0, 1'b1, 1'b0, 4'd8); exe_branch_taken = 1'b1;
        ex("c1", HZ, 0, 0); ex("c1", FL, 1, 1); tick;
        exe_branch_taken = 1'b0;
        id_set(4'd8, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        ex("c2_e_bubble", HZ, 0, 0); ex("c2", FL, 0, 0); tick;
        drain;

        // Four-cycle SRAM wait with a pending hazard and a deferred branch.
        id_set(4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd9);  ex("d0", HZ, 0, 0); tick;
        id_set(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd10); ex("d1", HZ, 0, 0); tick;
        id_set(4'd10, 4'd0, 1'b0, 1'b1, 1'b0, 4'd11);
        mem_req = 1'b1; sram_ready = 1'b0;
        ex("d2", FZ, 1, 1); ex("d2", HZ, 1, 0); ex("d2", TO, 0, 0); tick;
        exe_branch_taken = 1'b1;
        for (int i = 3; i <= 5; i++) begin
            ex($sformatf("d%0d", i), FZ, 1, 1);
            ex($sformatf("d%0d", i), FL, 0, 0);
            ex($sformatf("d%0d", i), HZ, 1, 0);
            ex($sformatf("d%0d", i), TO, 0, 0);
            tick;
        end
        sram_ready = 1'b1;
        ex("d6_ready", FZ, 0, 0); ex("d6_ready", FL, 1, 1);
        ex("d6_ready", HZ, 0, 0); ex("d6_ready", TO, 0, 1); tick;
        mem_req = 1'b0; sram_ready = 1'b0; exe_branch_taken = 1'b0;
        id_set(4'd10, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        ex("d7_held", HZ, 1, 0); ex("d7", FZ, 0, 0); ex("d7", FL, 0, 0);
        ex("d7_sticky", TO, 0, 1); tick;
        id_set(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        mem_req = 1'b1; sram_ready = 1'b1; ex("d8_fast", FZ, 0, 0); tick;
        mem_req = 1'b0; sram_ready = 1'b0; ex("d9_sticky", TO, 0, 1); tick;
        drain;

        // Reset clears the sticky timeout.
        rst = 1'b0; tick;
        rst = 1'b1; ex("rst2", TO, 0, 0); tick;

        // SRAM never ready: timeout on u1 (WAIT_MAX=3), then reset mid-wait.
        id_set(4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd12); ex("e0", FZ, 0, 0); tick;
        id_set(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        mem_req = 1'b1; sram_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            ex($sformatf("e%0d", i), FZ, 1, 1);
            ex($sformatf("e%0d", i), TO, 0, (i >= 5) ? 1'b1 : 1'b0);
            tick;
        end
        chk("expired_wait u1 timeout", tmo1, 1'b1);
        chk("expired_wait u0 timeout", tmo0, 1'b0);
        chk("expired_wait u1 freeze", freeze1, 1'b1);
        rst = 1'b0; mem_req = 1'b0; tick;
        rst = 1'b1;
        id_set(4'd12, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        ex("e8_rst", HZ, 0, 0); ex("e8_rst", FZ, 0, 0);
        ex("e8_rst", FL, 0, 0); ex("e8_rst", TO, 0, 0); tick;

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
